mem_arbiter: RTL and testbench

//  - Shares one unified single-port memory between the core's instruction-fetch port and its data (LD/ST) port.
//  - Sits between core and memory model/controller; the core stalls on its own while ready/valid are pending.
//  - Data requests have fixed priority over fetch. A streak counter prevents fetch starvation.
//  - Memory side is variable-latency: a req/ack handshake.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the core-side fetch/data handshakes and the
// memory-side req/ack handshake of the unified-memory arbiter.
//   slave  : arbiter view (takes core requests, drives the memory)
//   master : environment view (core ports plus memory model)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_valid;
  logic [DATA_W-1:0] i_r_data;
  // data (LD/ST) port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_w_data;
  logic              d_ready;
  logic              d_valid;
  logic [DATA_W-1:0] d_r_data;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_r_data;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_valid, i_r_data,
    input  d_req, d_we, d_addr, d_w_data,
    output d_ready, d_valid, d_r_data,
    output mem_req, mem_we, mem_addr, mem_w_data,
    input  mem_ack, mem_r_data
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_valid, i_r_data,
    output d_req, d_we, d_addr, d_w_data,
    input  d_ready, d_valid, d_r_data,
    input  mem_req, mem_we, mem_addr, mem_w_data,
    output mem_ack, mem_r_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch and data ports of a core. Data has fixed priority; a
// streak counter forces a fetch grant after D_STREAK_MAX consecutive data
// grants taken while a fetch was waiting.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave: i_* fetch handshake, d_* data handshake,
//          mem_* req/ack memory handshake (all outputs registered)
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int D_STREAK_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);
  localparam int STREAK_W = $clog2(D_STREAK_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_w_data_q, mem_w_data_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                i_valid_q, i_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   i_r_data_q, i_r_data_d;
  logic [DATA_W-1:0]   d_r_data_q, d_r_data_d;

  logic grant_i, grant_d, streak_at_max;

  assign streak_at_max = (streak_q == STREAK_W'(D_STREAK_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      i_r_data_q   <= '0;
      d_r_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_valid_q    <= i_valid_d;
      d_valid_q    <= d_valid_d;
      i_r_data_q   <= i_r_data_d;
      d_r_data_q   <= d_r_data_d;
    end
  end

  // Next-state: grants only from IDLE; requests are ignored while busy
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && streak_at_max)) begin
          state_d = BUSY_D;
          grant_d = 1'b1;
        end else if (bus.i_req) begin
          state_d = BUSY_I;
          grant_i = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is registered, so this computes the next flop values
  always_comb begin
    streak_d     = streak_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    i_r_data_d   = i_r_data_q;
    d_r_data_d   = d_r_data_q;

    if (grant_d) begin
      mem_req_d    = 1'b1;
      mem_we_d     = bus.d_we;
      mem_addr_d   = bus.d_addr;
      mem_w_data_d = bus.d_w_data;
      d_ready_d    = 1'b1;
      // streak only grows while a fetch is actually being held off
      if (!bus.i_req)         streak_d = '0;
      else if (!streak_at_max) streak_d = streak_q + STREAK_W'(1);
    end else if (grant_i) begin
      mem_req_d    = 1'b1;
      mem_we_d     = 1'b0;
      mem_addr_d   = bus.i_addr;
      mem_w_data_d = '0;
      i_ready_d    = 1'b1;
      streak_d     = '0;
    end else if (state_q != IDLE && bus.mem_ack) begin
      mem_req_d = 1'b0;
      if (state_q == BUSY_I) begin
        i_valid_d  = 1'b1;
        i_r_data_d = bus.mem_r_data;
      end else begin
        d_valid_d  = 1'b1;
        d_r_data_d = mem_we_q ? '0 : bus.mem_r_data;
      end
    end
  end

  assign bus.i_ready    = i_ready_q;
  assign bus.i_valid    = i_valid_q;
  assign bus.i_r_data   = i_r_data_q;
  assign bus.d_ready    = d_ready_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_r_data   = d_r_data_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant rule, streak count, reference memory).
module tb_mem_arbiter;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK_MAX(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] rsp_mem [bit [31:0]];

  function automatic bit [31:0] dflt(input bit [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit [31:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic bit [31:0] rsp_rd(input bit [31:0] a);
    return rsp_mem.exists(a) ? rsp_mem[a] : dflt(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_w_data = '0;
    bus.mem_ack = 1'b0; bus.mem_r_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.i_ready !== 1'b0) $display("FAIL rst_i_ready got=%h exp=0", bus.i_ready); else n_pass++;
    n_checks++; if (bus.i_valid !== 1'b0) $display("FAIL rst_i_valid got=%h exp=0", bus.i_valid); else n_pass++;
    n_checks++; if (bus.i_r_data !== 32'h0) $display("FAIL rst_i_r_data got=%h exp=0", bus.i_r_data); else n_pass++;
    n_checks++; if (bus.d_ready !== 1'b0) $display("FAIL rst_d_ready got=%h exp=0", bus.d_ready); else n_pass++;
    n_checks++; if (bus.d_valid !== 1'b0) $display("FAIL rst_d_valid got=%h exp=0", bus.d_valid); else n_pass++;
    n_checks++; if (bus.d_r_data !== 32'h0) $display("FAIL rst_d_r_data got=%h exp=0", bus.d_r_data); else n_pass++;
    n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got=%h exp=0", bus.mem_req); else n_pass++;
    n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we got=%h exp=0", bus.mem_we); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_w_data !== 32'h0) $display("FAIL rst_mem_w_data got=%h exp=0", bus.mem_w_data); else n_pass++;
    step();
    n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_idle_mem_req got=%h exp=0", bus.mem_req); else n_pass++;
  endtask

  task automatic test_single_fetch();
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    step();
    n_checks++; if (bus.i_ready !== 1'b1) $display("FAIL sf_i_ready got=%h exp=1", bus.i_ready); else n_pass++;
    n_checks++; if (bus.mem_req !== 1'b1) $display("FAIL sf_mem_req got=%h exp=1", bus.mem_req); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h10) $display("FAIL sf_mem_addr got=%h exp=10", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL sf_mem_we got=%h exp=0", bus.mem_we); else n_pass++;
    n_checks++; if (bus.i_valid !== 1'b0) $display("FAIL sf_early_valid got=%h exp=0", bus.i_valid); else n_pass++;
    bus.i_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'hDEAD_BEEF;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.i_valid !== 1'b1) $display("FAIL sf_i_valid got=%h exp=1", bus.i_valid); else n_pass++;
    n_checks++; if (bus.i_r_data !== 32'hDEAD_BEEF) $display("FAIL sf_i_r_data got=%h exp=deadbeef", bus.i_r_data); else n_pass++;
    n_checks++; if (bus.i_ready !== 1'b0) $display("FAIL sf_ready_pulse got=%h exp=0", bus.i_ready); else n_pass++;
    n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL sf_mem_req_drop got=%h exp=0", bus.mem_req); else n_pass++;
    step();
    n_checks++; if (bus.i_valid !== 1'b0) $display("FAIL sf_valid_pulse got=%h exp=0", bus.i_valid); else n_pass++;
    n_checks++; if (bus.i_r_data !== 32'hDEAD_BEEF) $display("FAIL sf_i_r_data_hold got=%h exp=deadbeef", bus.i_r_data); else n_pass++;
  endtask

  task automatic test_store_load();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_w_data = 32'h55;
    step();
    n_checks++; if (bus.d_ready !== 1'b1) $display("FAIL sl_st_ready got=%h exp=1", bus.d_ready); else n_pass++;
    n_checks++; if (bus.mem_we !== 1'b1) $display("FAIL sl_st_mem_we got=%h exp=1", bus.mem_we); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h8) $display("FAIL sl_st_mem_addr got=%h exp=8", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_w_data !== 32'h55) $display("FAIL sl_st_mem_w_data got=%h exp=55", bus.mem_w_data); else n_pass++;
    bus.d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (bus.mem_req !== 1'b1) $display("FAIL sl_mem_req_held[%0d] got=%h exp=1", k, bus.mem_req); else n_pass++;
      n_checks++; if (bus.d_valid !== 1'b0) $display("FAIL sl_no_valid[%0d] got=%h exp=0", k, bus.d_valid); else n_pass++;
    end
    bus.mem_ack = 1'b1; bus.mem_r_data = 32'hFFFF_FFFF;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.d_valid !== 1'b1) $display("FAIL sl_st_valid got=%h exp=1", bus.d_valid); else n_pass++;
    n_checks++; if (bus.d_r_data !== 32'h0) $display("FAIL sl_st_r_data got=%h exp=0", bus.d_r_data); else n_pass++;
    n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL sl_st_mem_req got=%h exp=0", bus.mem_req); else n_pass++;
    // new load raised in the valid cycle: granted at the next edge
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
    step();
    n_checks++; if (bus.d_ready !== 1'b1) $display("FAIL sl_ld_ready got=%h exp=1", bus.d_ready); else n_pass++;
    n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL sl_ld_mem_we got=%h exp=0", bus.mem_we); else n_pass++;
    bus.d_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'h55;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.d_valid !== 1'b1) $display("FAIL sl_ld_valid got=%h exp=1", bus.d_valid); else n_pass++;
    n_checks++; if (bus.d_r_data !== 32'h55) $display("FAIL sl_ld_r_data got=%h exp=55", bus.d_r_data); else n_pass++;
    step();
  endtask

  task automatic test_conflict();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    step();
    n_checks++; if (bus.d_ready !== 1'b1) $display("FAIL cf_d_first got=%h exp=1", bus.d_ready); else n_pass++;
    n_checks++; if (bus.i_ready !== 1'b0) $display("FAIL cf_i_wait got=%h exp=0", bus.i_ready); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h200) $display("FAIL cf_d_addr got=%h exp=200", bus.mem_addr); else n_pass++;
    bus.d_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'h1111;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.d_valid !== 1'b1) $display("FAIL cf_d_valid got=%h exp=1", bus.d_valid); else n_pass++;
    n_checks++; if (bus.i_ready !== 1'b0) $display("FAIL cf_i_not_yet got=%h exp=0", bus.i_ready); else n_pass++;
    step();
    n_checks++; if (bus.i_ready !== 1'b1) $display("FAIL cf_i_second got=%h exp=1", bus.i_ready); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h100) $display("FAIL cf_i_addr got=%h exp=100", bus.mem_addr); else n_pass++;
    bus.i_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'h2222;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.i_r_data !== 32'h2222) $display("FAIL cf_i_data got=%h exp=2222", bus.i_r_data); else n_pass++;
    step();
  endtask

  task automatic test_starvation();
    logic [10:0] exp_seq;  // bit g = 1 when grant g goes to the data port
    exp_seq = 11'b101_1110_1111;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    for (int g = 0; g < 11; g++) begin
      step();
      n_checks++; if (bus.d_ready !== exp_seq[g]) $display("FAIL sv_d_grant[%0d] got=%h exp=%h", g, bus.d_ready, exp_seq[g]); else n_pass++;
      n_checks++; if (bus.i_ready !== !exp_seq[g]) $display("FAIL sv_i_grant[%0d] got=%h exp=%h", g, bus.i_ready, !exp_seq[g]); else n_pass++;
      bus.mem_ack = 1'b1; bus.mem_r_data = 32'(g);
      step();
      bus.mem_ack = 1'b0;
      if (g == 10) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    step();
    n_checks++; if (bus.d_ready !== 1'b1) $display("FAIL rm_d_ready got=%h exp=1", bus.d_ready); else n_pass++;
    bus.d_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'h1234;
    n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rm_mem_req got=%h exp=0", bus.mem_req); else n_pass++;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.d_valid !== 1'b0) $display("FAIL rm_late_ack_valid got=%h exp=0", bus.d_valid); else n_pass++;
    n_checks++; if (bus.d_r_data !== 32'h0) $display("FAIL rm_d_r_data got=%h exp=0", bus.d_r_data); else n_pass++;
    n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rm_mem_req_after got=%h exp=0", bus.mem_req); else n_pass++;
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    step();
    n_checks++; if (bus.i_ready !== 1'b1) $display("FAIL rm_i_ready got=%h exp=1", bus.i_ready); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h44) $display("FAIL rm_i_addr got=%h exp=44", bus.mem_addr); else n_pass++;
    bus.i_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'hCAFE;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.i_valid !== 1'b1) $display("FAIL rm_i_valid got=%h exp=1", bus.i_valid); else n_pass++;
    n_checks++; if (bus.i_r_data !== 32'hCAFE) $display("FAIL rm_i_data got=%h exp=cafe", bus.i_r_data); else n_pass++;
    step();
  endtask

  task automatic test_spurious();
    bus.mem_ack = 1'b1; bus.mem_r_data = 32'hBAD0_BAD0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if ({bus.i_valid, bus.d_valid} !== 2'b00) $display("FAIL sp_idle_valid[%0d] got=%b exp=00", k, {bus.i_valid, bus.d_valid}); else n_pass++;
      n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL sp_idle_mem_req[%0d] got=%h exp=0", k, bus.mem_req); else n_pass++;
    end
    bus.mem_ack = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    step();
    bus.i_req = 1'b0;
    // data request raised and withdrawn while the fetch is in flight
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h90; bus.d_w_data = 32'h77;
    step();
    bus.d_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_r_data = 32'h8080;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if (bus.i_valid !== 1'b1) $display("FAIL sp_i_valid got=%h exp=1", bus.i_valid); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (bus.d_ready !== 1'b0) $display("FAIL sp_dropped_ready[%0d] got=%h exp=0", k, bus.d_ready); else n_pass++;
      n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL sp_dropped_mem_req[%0d] got=%h exp=0", k, bus.mem_req); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit          busy = 1'b0, own_d = 1'b0;
    int unsigned lat = 0, streak = 0;
    bit          e_ir = 1'b0, e_dr = 1'b0, e_iv = 1'b0, e_dv = 1'b0, e_mreq = 1'b0, e_mwe = 1'b0;
    bit [31:0]   e_maddr = '0, e_mwdata = '0, e_idata = '0, e_ddata = '0, pend = '0;
    ref_mem.delete();
    rsp_mem.delete();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      n_checks++; if (bus.i_ready !== e_ir) $display("FAIL rnd_i_ready c=%0d got=%h exp=%h", c, bus.i_ready, e_ir); else n_pass++;
      n_checks++; if (bus.d_ready !== e_dr) $display("FAIL rnd_d_ready c=%0d got=%h exp=%h", c, bus.d_ready, e_dr); else n_pass++;
      n_checks++; if (bus.i_valid !== e_iv) $display("FAIL rnd_i_valid c=%0d got=%h exp=%h", c, bus.i_valid, e_iv); else n_pass++;
      n_checks++; if (bus.d_valid !== e_dv) $display("FAIL rnd_d_valid c=%0d got=%h exp=%h", c, bus.d_valid, e_dv); else n_pass++;
      n_checks++; if (bus.mem_req !== e_mreq) $display("FAIL rnd_mem_req c=%0d got=%h exp=%h", c, bus.mem_req, e_mreq); else n_pass++;
      n_checks++; if (bus.i_r_data !== e_idata) $display("FAIL rnd_i_r_data c=%0d got=%h exp=%h", c, bus.i_r_data, e_idata); else n_pass++;
      n_checks++; if (bus.d_r_data !== e_ddata) $display("FAIL rnd_d_r_data c=%0d got=%h exp=%h", c, bus.d_r_data, e_ddata); else n_pass++;
      if (e_mreq) begin
        n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_w_data} !== {e_mwe, e_maddr, e_mwdata})
          $display("FAIL rnd_mem_cmd c=%0d got=%h/%h/%h exp=%h/%h/%h", c, bus.mem_we, bus.mem_addr, bus.mem_w_data, e_mwe, e_maddr, e_mwdata);
        else n_pass++;
      end

      // core side: drop a request once accepted, raise new ones at random
      bus.mem_ack = 1'b0;
      if (e_ir) bus.i_req = 1'b0;
      if (e_dr) bus.d_req = 1'b0;
      if (!bus.i_req && $urandom_range(0, 2) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = $urandom_range(0, 31);
      end
      if (!bus.d_req && $urandom_range(0, 3) != 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom_range(0, 31); bus.d_w_data = $urandom;
      end

      e_ir = 1'b0; e_dr = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
      if (busy) begin
        if (lat == 0) begin
          bus.mem_ack = 1'b1;
          if (e_mwe) begin
            rsp_mem[bus.mem_addr] = bus.mem_w_data;
            bus.mem_r_data = $urandom;
          end else begin
            bus.mem_r_data = rsp_rd(bus.mem_addr);
          end
          busy = 1'b0; e_mreq = 1'b0;
          if (own_d) begin e_dv = 1'b1; e_ddata = pend; end
          else       begin e_iv = 1'b1; e_idata = pend; end
        end else begin
          lat--;
        end
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          bus.mem_ack = 1'b1; bus.mem_r_data = $urandom;
        end
        if (bus.d_req && !(bus.i_req && streak == MAX)) begin
          own_d = 1'b1; e_dr = 1'b1;
          e_mwe = bus.d_we; e_maddr = bus.d_addr; e_mwdata = bus.d_w_data;
          if (bus.d_we) begin ref_mem[bus.d_addr] = bus.d_w_data; pend = '0; end
          else pend = ref_rd(bus.d_addr);
          streak = bus.i_req ? ((streak < MAX) ? streak + 1 : MAX) : 0;
          busy = 1'b1;
        end else if (bus.i_req) begin
          own_d = 1'b0; e_ir = 1'b1;
          e_mwe = 1'b0; e_maddr = bus.i_addr; e_mwdata = '0;
          pend = ref_rd(bus.i_addr);
          streak = 0;
          busy = 1'b1;
        end
        if (busy) begin
          lat = $urandom_range(0, 3);
          e_mreq = 1'b1;
        end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store_load();
    test_conflict();
    test_starvation();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
